// File: rtl/dm_sbus_bridge.sv
// Bridge between the SBA FSM req/gnt/r_valid port and the SoC bus.
// Gnt is combinational in Idle; bus_req_o rises 1 cycle after accept; the response comes 1 cycle after bus_r_valid_i or the timeout.
// Backpressure: one transaction outstanding; sba_gnt_o stays low until the bus side is back in Idle.
module dm_sbus_bridge #(
    parameter int BusWidth      = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic                  sba_req_i,
    input  logic [BusWidth-1:0]   sba_add_i,
    input  logic                  sba_we_i,
    input  logic [BusWidth-1:0]   sba_wdata_i,
    input  logic [BusWidth/8-1:0] sba_be_i,
    output logic                  sba_gnt_o,
    output logic                  sba_r_valid_o,
    output logic [BusWidth-1:0]   sba_r_rdata_o,
    output logic                  bus_req_o,
    output logic [BusWidth-1:0]   bus_add_o,
    output logic                  bus_we_o,
    output logic [BusWidth-1:0]   bus_wdata_o,
    output logic [BusWidth/8-1:0] bus_be_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_r_valid_i,
    input  logic [BusWidth-1:0]   bus_r_rdata_i,
    input  logic                  bus_r_err_i,
    output logic                  err_valid_o,
    output logic [2:0]            err_o
);

    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CntW-1:0]       r_cnt;
    logic                  w_gnt;
    logic                  w_tmo;
    logic                  w_rsp_vld;
    logic [2:0]            w_rsp_err;
    logic [BusWidth-1:0]   w_rsp_rdata;
    logic                  r_rsp_vld;
    logic                  r_err_vld;
    logic [2:0]            r_err;
    logic [BusWidth-1:0]   r_rdata;
    logic [BusWidth-1:0]   r_bus_add;
    logic                  r_bus_we;
    logic [BusWidth-1:0]   r_bus_wdata;
    logic [BusWidth/8-1:0] r_bus_be;

    assign w_tmo = (TimeoutCycles > 0) && (r_cnt == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A bus event in the same cycle as the timeout always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_rsp_vld   = 1'b0;
        w_rsp_err   = 3'd0;
        w_rsp_rdata = '0;
        case (r_state)
            IDLE: begin
                w_gnt = sba_req_i & dmactive_i;
                if (w_gnt) w_state_nxt = REQ;
            end
            REQ: begin
                if (!dmactive_i) begin
                    w_state_nxt = bus_gnt_i ? DRAIN : IDLE;
                end else if (bus_gnt_i) begin
                    w_state_nxt = WAIT_RSP;
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                    w_rsp_vld   = 1'b1;
                    w_rsp_err   = 3'd1;
                end
            end
            WAIT_RSP: begin
                if (bus_r_valid_i) begin
                    w_state_nxt = IDLE;
                    w_rsp_vld   = dmactive_i;
                    if (!r_bus_we) w_rsp_rdata = bus_r_rdata_i;
                    if (bus_r_err_i && dmactive_i) w_rsp_err = 3'd2;
                end else if (!dmactive_i) begin
                    w_state_nxt = DRAIN;
                end else if (w_tmo) begin
                    w_state_nxt = DRAIN;
                    w_rsp_vld   = 1'b1;
                    w_rsp_err   = 3'd1;
                end
            end
            DRAIN: begin
                if (bus_r_valid_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_gnt) begin
            r_cnt <= '0;
        end else if ((r_state == REQ || r_state == WAIT_RSP) && r_cnt != {CntW{1'b1}}) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_vld <= 1'b0;
            r_err_vld <= 1'b0;
            r_err     <= 3'd0;
            r_rdata   <= '0;
        end else begin
            r_rsp_vld <= w_rsp_vld;
            r_err_vld <= w_rsp_vld && (w_rsp_err != 3'd0);
            r_err     <= w_rsp_err;
            r_rdata   <= w_rsp_rdata;
        end
    end

    // Request fields are only loaded on accept, so they stay stable for the whole bus phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bus_add   <= '0;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
        end else if (w_gnt) begin
            r_bus_add   <= sba_add_i;
            r_bus_we    <= sba_we_i;
            r_bus_wdata <= sba_wdata_i;
            r_bus_be    <= sba_be_i;
        end
    end

    assign sba_gnt_o     = w_gnt;
    assign sba_r_valid_o = r_rsp_vld & dmactive_i;
    assign sba_r_rdata_o = r_rdata;
    assign err_valid_o   = r_err_vld & dmactive_i;
    assign err_o         = err_valid_o ? r_err : 3'd0;
    assign bus_req_o     = (r_state == REQ);
    assign bus_add_o     = r_bus_add;
    assign bus_we_o      = r_bus_we;
    assign bus_wdata_o   = r_bus_wdata;
    assign bus_be_o      = r_bus_be;

endmodule

// File: tb/tb_dm_sbus_bridge.sv
// Directed bench for dm_sbus_bridge (TimeoutCycles=8): scenario tasks book the expected
// response per cycle in a scoreboard, and a negedge process checks every cycle against it.
module tb_dm_sbus_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dmactive_i;
    logic        sba_req_i;
    logic [31:0] sba_add_i;
    logic        sba_we_i;
    logic [31:0] sba_wdata_i;
    logic [3:0]  sba_be_i;
    logic        sba_gnt_o;
    logic        sba_r_valid_o;
    logic [31:0] sba_r_rdata_o;
    logic        bus_req_o;
    logic [31:0] bus_add_o;
    logic        bus_we_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_r_valid_i;
    logic [31:0] bus_r_rdata_i;
    logic        bus_r_err_i;
    logic        err_valid_o;
    logic [2:0]  err_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;

    // Scoreboard: cycle -> expected response (error code 0 means plain response).
    int          exp_err[int];
    logic [31:0] exp_rd[int];

    dm_sbus_bridge #(.BusWidth(32), .TimeoutCycles(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
        .sba_req_i(sba_req_i), .sba_add_i(sba_add_i), .sba_we_i(sba_we_i),
        .sba_wdata_i(sba_wdata_i), .sba_be_i(sba_be_i), .sba_gnt_o(sba_gnt_o),
        .sba_r_valid_o(sba_r_valid_o), .sba_r_rdata_o(sba_r_rdata_o),
        .bus_req_o(bus_req_o), .bus_add_o(bus_add_o), .bus_we_o(bus_we_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
        .bus_r_valid_i(bus_r_valid_i), .bus_r_rdata_i(bus_r_rdata_i),
        .bus_r_err_i(bus_r_err_i), .err_valid_o(err_valid_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            if (exp_err.exists(cyc)) begin
                chk("rsp_valid", sba_r_valid_o, 1);
                chk("rsp_rdata", sba_r_rdata_o, exp_rd[cyc]);
                chk("rsp_err_valid", err_valid_o, exp_err[cyc] != 0);
                chk("rsp_err_code", err_o, exp_err[cyc]);
                exp_err.delete(cyc);
                exp_rd.delete(cyc);
            end else begin
                chk("no_rsp_pulse", sba_r_valid_o, 0);
                chk("no_err_pulse", {err_valid_o, err_o}, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_rsp(input int c, input logic [31:0] d, input int e);
        exp_err[c] = e;
        exp_rd[c]  = d;
    endtask

    // Holds a request until granted; returns the accept cycle and leaves the bench in the first Req cycle.
    task automatic accept(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] be, output int n);
        int k;
        sba_req_i = 1'b1; sba_add_i = a; sba_we_i = we; sba_wdata_i = wd; sba_be_i = be;
        #1;
        k = 0;
        while (!sba_gnt_o && k < 60) begin
            step();
            #1;
            k++;
        end
        chk("accept_gnt", sba_gnt_o, 1);
        n = cyc;
        step();
        sba_req_i = 1'b0;
    endtask

    // From the first Req cycle: grant at once, respond a cycle later.
    task automatic finish_read(input int n, input logic [31:0] d);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0; bus_r_valid_i = 1'b1; bus_r_rdata_i = d;
        expect_rsp(n + 3, d, 0);
        step();
        bus_r_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        rst_ni = 1'b0; dmactive_i = 1'b1; sba_req_i = 1'b0; sba_add_i = '0; sba_we_i = 1'b0;
        sba_wdata_i = '0; sba_be_i = '0; bus_gnt_i = 1'b0; bus_r_valid_i = 1'b0;
        bus_r_rdata_i = '0; bus_r_err_i = 1'b0;
        step(); step();
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_add", bus_add_o, 0);
        chk("rst_bus_be", bus_be_o, 0);
        chk("rst_rsp", {sba_r_valid_o, err_valid_o, err_o}, 0);
        rst_ni = 1'b1;
        step();
        chk_en = 1'b1;

        // Read: grant in 2nd Req cycle, a stray r_valid in Req must be ignored.
        accept(32'h1000, 1'b0, 32'h0, 4'hF, n);
        bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'h111;
        #1;
        chk("rd_bus_req_c1", bus_req_o, 1);
        chk("rd_bus_add", bus_add_o, 32'h1000);
        step();
        bus_r_valid_i = 1'b0; bus_gnt_i = 1'b1;
        chk("rd_bus_req_c2", bus_req_o, 1);
        step();
        bus_gnt_i = 1'b0; bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'hDEADBEEF;
        chk("rd_bus_req_c3", bus_req_o, 0);
        expect_rsp(n + 4, 32'hDEADBEEF, 0);
        step();
        bus_r_valid_i = 1'b0;
        chk("rd_lit_valid", sba_r_valid_o, 1);
        chk("rd_lit_rdata", sba_r_rdata_o, 32'hDEADBEEF);
        step();

        // Write: rdata returned must be zero regardless of bus data.
        accept(32'h2004, 1'b1, 32'hA5, 4'b0001, n);
        chk("wr_be", bus_be_o, 4'b0001);
        chk("wr_we", bus_we_o, 1);
        chk("wr_wdata", bus_wdata_o, 32'hA5);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0; bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'h12345678;
        chk("wr_be_held", bus_be_o, 4'b0001);
        expect_rsp(n + 3, 32'h0, 0);
        step();
        bus_r_valid_i = 1'b0;
        step();

        // Bus error.
        accept(32'h3000, 1'b0, 32'h0, 4'hF, n);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0; bus_r_valid_i = 1'b1; bus_r_err_i = 1'b1; bus_r_rdata_i = 32'h0;
        expect_rsp(n + 3, 32'h0, 2);
        step();
        bus_r_valid_i = 1'b0; bus_r_err_i = 1'b0;
        chk("berr_lit_code", err_o, 3'd2);
        step();

        // Timeout without grant: 8 Req cycles, then error and immediate re-grant.
        accept(32'h4000, 1'b0, 32'h0, 4'hF, n);
        expect_rsp(n + 9, 32'h0, 1);
        while (cyc < n + 8) step();
        chk("to_req_last", bus_req_o, 1);
        step();
        chk("to_req_drop", bus_req_o, 0);
        chk("to_lit_code", err_o, 3'd1);
        accept(32'h4100, 1'b0, 32'h0, 4'hF, m);
        chk("to_regrant_cyc", m, n + 9);
        finish_read(m, 32'h55AA);
        step();

        // Timeout after grant, late r_valid at accept+20 with a new request held.
        accept(32'h5000, 1'b0, 32'h0, 4'hF, n);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        sba_req_i = 1'b1; sba_add_i = 32'h6000; sba_we_i = 1'b0;
        expect_rsp(n + 9, 32'h0, 1);
        while (cyc < n + 20) begin
            #1;
            chk("late_gnt_blocked", sba_gnt_o, 0);
            step();
        end
        bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'hBAD;
        #1;
        chk("late_gnt_blocked_last", sba_gnt_o, 0);
        step();
        bus_r_valid_i = 1'b0;
        accept(32'h6000, 1'b0, 32'h0, 4'hF, m);
        chk("late_regrant_cyc", m, n + 21);
        finish_read(m, 32'h600D);
        step();

        // dmactive low during WaitRsp: response swallowed, no pulse.
        accept(32'h7000, 1'b0, 32'h0, 4'hF, n);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0; dmactive_i = 1'b0;
        step();
        dmactive_i = 1'b1;
        step();
        bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'h777; sba_req_i = 1'b1; sba_add_i = 32'h7100;
        #1;
        chk("dm_drain_gnt", sba_gnt_o, 0);
        step();
        bus_r_valid_i = 1'b0;
        accept(32'h7100, 1'b0, 32'h0, 4'hF, m);
        chk("dm_regrant_cyc", m, n + 5);
        finish_read(m, 32'h7777);
        repeat (3) step();

        chk("scoreboard_drained", exp_err.num(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
